// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the two-requester seven-segment display arbiter.
package sevenseg_pkg;

    localparam int DISP_WIDTH = 16;
    localparam logic [DISP_WIDTH-1:0] IDLE_PATTERN_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    // Bits needed for a counter that runs 0 .. cycles-1, never less than one.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/sevenseg_tick_counter.sv
// Clearable cycle counter with terminal-count flag; either saturates at the
// last count (hold timer) or wraps back to zero (blink timer).
module sevenseg_tick_counter
    import sevenseg_pkg::*;
#(
    parameter int MAX_COUNT = 4,
    parameter bit WRAP      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int W = cnt_width(MAX_COUNT);
    localparam logic [W-1:0] LAST = W'(MAX_COUNT - 1);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            if (count_q == LAST) begin
                count_d = WRAP ? '0 : LAST;
            end else begin
                count_d = count_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign terminal = (count_q == LAST);

endmodule

// File: rtl/sevenseg_arbiter.sv
// Arbitrates two display sources onto one registered seven-segment word with a
// minimum owner tenure. Define SEVENSEG_ARB_BLINK_EN to blink owner 0's display.
module sevenseg_arbiter
    import sevenseg_pkg::*;
#(
    parameter int HOLD_CYCLES  = 100_000_000,
    parameter int BLINK_CYCLES = 50_000_000,
    parameter logic [DISP_WIDTH-1:0] IDLE_PATTERN = IDLE_PATTERN_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [DISP_WIDTH-1:0] data0,
    input  logic [DISP_WIDTH-1:0] data1,
    output logic                  grant0,
    output logic                  grant1,
    output logic [DISP_WIDTH-1:0] seg_data,
    output logic                  seg_blank,
    output logic                  switch_pulse,
    output arb_state_e            dbg_state
);

    arb_state_e state_q, state_d;
    logic [DISP_WIDTH-1:0] seg_data_q, seg_data_d;
    logic seg_blank_q, seg_blank_d;
    logic switch_pulse_q, switch_pulse_d;
    logic hold_done;
    logic entering;
    logic own0_blank;

    assign entering = (state_d != state_q);

    // Tenure timer restarts on every ownership change and idles at zero.
    sevenseg_tick_counter #(
        .MAX_COUNT(HOLD_CYCLES),
        .WRAP     (1'b0)
    ) u_hold (
        .clk     (clk),
        .rst     (rst),
        .clear   (entering || (state_d == ST_IDLE)),
        .enable  (1'b1),
        .terminal(hold_done)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req0) begin
                    state_d = ST_OWN0;
                end else if (req1) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!req0) begin
                    state_d = req1 ? ST_OWN1 : ST_IDLE;
                end else if (req1 && hold_done) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN1: begin
                if (!req1) begin
                    state_d = req0 ? ST_OWN0 : ST_IDLE;
                end else if (req0 && hold_done) begin
                    state_d = ST_OWN0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef SEVENSEG_ARB_BLINK_EN
    logic phase_q, phase_d;
    logic blink_tc;
    logic blink_clear;
    logic blink_en;

    assign blink_clear = (state_d == ST_OWN0) && (state_q != ST_OWN0);
    assign blink_en    = (state_d == ST_OWN0) && (state_q == ST_OWN0);

    sevenseg_tick_counter #(
        .MAX_COUNT(BLINK_CYCLES),
        .WRAP     (1'b1)
    ) u_blink (
        .clk     (clk),
        .rst     (rst),
        .clear   (blink_clear),
        .enable  (blink_en),
        .terminal(blink_tc)
    );

    always_comb begin
        phase_d = phase_q;
        if (blink_clear) begin
            phase_d = 1'b0;
        end else if (blink_en && blink_tc) begin
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign own0_blank = phase_d;
`else
    logic unused_blink_cfg;
    assign unused_blink_cfg = (BLINK_CYCLES > 0);
    assign own0_blank       = 1'b0;
`endif

    // Outputs are computed from the next state so they line up with the grant.
    always_comb begin
        seg_data_d     = IDLE_PATTERN;
        seg_blank_d    = 1'b1;
        switch_pulse_d = entering;
        case (state_d)
            ST_OWN0: begin
                seg_data_d  = data0;
                seg_blank_d = own0_blank;
            end
            ST_OWN1: begin
                seg_data_d  = data1;
                seg_blank_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            seg_data_q     <= IDLE_PATTERN;
            seg_blank_q    <= 1'b1;
            switch_pulse_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            seg_data_q     <= seg_data_d;
            seg_blank_q    <= seg_blank_d;
            switch_pulse_q <= switch_pulse_d;
        end
    end

    assign grant0       = (state_q == ST_OWN0);
    assign grant1       = (state_q == ST_OWN1);
    assign seg_data     = seg_data_q;
    assign seg_blank    = seg_blank_q;
    assign switch_pulse = switch_pulse_q;
    assign dbg_state    = state_q;

endmodule
